// File: rtl/controle_pkg.sv
// Shared types for the multicycle RV32I control FSM: state encoding, opcodes
// and the mux-select encodings driven towards the datapath.
package controle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_EXEC_I   = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ESPERA   = 4'd14,
        S_ERRO     = 4'd15
    } estado_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_IMM    = 2'b11;

    localparam logic [1:0] ULA_A_PCBACK = 2'b00;
    localparam logic [1:0] ULA_A_REGA   = 2'b01;
    localparam logic [1:0] ULA_A_PC     = 2'b10;

    localparam logic [1:0] ULA_B_REGB = 2'b00;
    localparam logic [1:0] ULA_B_4    = 2'b01;
    localparam logic [1:0] ULA_B_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_ALU_JALR = 2'b10;

    // States that complete an instruction; the FSM leaves them for the next fetch.
    function automatic logic isTerminal(input estado_t e);
        case (e)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH,
            S_JAL, S_JALR, S_LUI, S_AUIPC: isTerminal = 1'b1;
            default:                       isTerminal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/controle_multiciclo_decod_opcode.sv
// Combinational opcode dispatch used by the DECODE state; any opcode outside
// the supported RV32I subset (including bits[1:0] != 11) maps to ERRO.
module decod_opcode
    import controle_pkg::*;
(
    input  logic [6:0] i_opcode,
    output estado_t    o_estado
);

    always_comb begin
        o_estado = S_ERRO;
        case (i_opcode)
            OPC_LOAD,
            OPC_STORE:  o_estado = S_MEMADR;
            OPC_RTYPE:  o_estado = S_EXEC_R;
            OPC_ITYPE:  o_estado = S_EXEC_I;
            OPC_BRANCH: o_estado = S_BRANCH;
            OPC_JAL:    o_estado = S_JAL;
            OPC_JALR:   o_estado = S_JALR;
            OPC_LUI:    o_estado = S_LUI;
            OPC_AUIPC:  o_estado = S_AUIPC;
            default:    o_estado = S_ERRO;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore control FSM for the multicycle RV32I datapath, one state per CPU clock.
// Optional single-step mode (state ESPERA + Passo input) under PASSO_A_PASSO_EN.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int ALUOP_W = 2
) (
    input  logic               clockCPU,
    input  logic               Reset,
`ifdef PASSO_A_PASSO_EN
    input  logic               Passo,
`endif
    input  logic [6:0]         Opcode,
    output logic [STATE_W-1:0] Estado,
    output logic               EscrevePC,
    output logic               EscrevePCCond,
    output logic               EscrevePCBack,
    output logic               IouD,
    output logic               LeMem,
    output logic               EscreveMem,
    output logic               EscreveIR,
    output logic               EscreveReg,
    output logic [1:0]         Mem2Reg,
    output logic [1:0]         OrigAULA,
    output logic [1:0]         OrigBULA,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         OrigPC,
    output logic               Halt
);

    estado_t    r_estado;
    estado_t    w_proximo;
    estado_t    w_despacho;
    estado_t    w_fimInstr;
    logic [1:0] w_aluOp;

    decod_opcode u_decod (
        .i_opcode (Opcode),
        .o_estado (w_despacho)
    );

`ifdef PASSO_A_PASSO_EN
    logic r_passoSync1;
    logic r_passoSync2;
    logic r_passoPrev;
    logic w_passoSobe;

    always_ff @(posedge clockCPU or negedge Reset) begin
        if (!Reset) begin
            r_passoSync1 <= 1'b0;
            r_passoSync2 <= 1'b0;
            r_passoPrev  <= 1'b0;
        end else begin
            r_passoSync1 <= Passo;
            r_passoSync2 <= r_passoSync1;
            r_passoPrev  <= r_passoSync2;
        end
    end

    assign w_passoSobe = r_passoSync2 & ~r_passoPrev;
    assign w_fimInstr  = S_ESPERA;
`else
    assign w_fimInstr  = S_FETCH;
`endif

    always_ff @(posedge clockCPU or negedge Reset) begin
        if (!Reset) r_estado <= S_FETCH;
        else        r_estado <= w_proximo;
    end

    always_comb begin
        w_proximo = S_ERRO;
        if (isTerminal(r_estado)) begin
            w_proximo = w_fimInstr;
        end else begin
            case (r_estado)
                S_FETCH:   w_proximo = S_DECODE;
                S_DECODE:  w_proximo = w_despacho;
                S_MEMADR:  w_proximo = (Opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: w_proximo = S_MEMWB;
                S_EXEC_R,
                S_EXEC_I:  w_proximo = S_ALUWB;
`ifdef PASSO_A_PASSO_EN
                S_ESPERA:  w_proximo = w_passoSobe ? S_FETCH : S_ESPERA;
`endif
                S_ERRO:    w_proximo = S_ERRO;
                default:   w_proximo = S_ERRO;
            endcase
        end
    end

    // Output decode; ESPERA, the unused code 14 and anything unlisted leave all controls low.
    always_comb begin
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        EscrevePCBack = 1'b0;
        IouD          = 1'b0;
        LeMem         = 1'b0;
        EscreveMem    = 1'b0;
        EscreveIR     = 1'b0;
        EscreveReg    = 1'b0;
        Mem2Reg       = M2R_ALUOUT;
        OrigAULA      = ULA_A_PCBACK;
        OrigBULA      = ULA_B_REGB;
        w_aluOp       = ALUOP_ADD;
        OrigPC        = PC_ALU;
        Halt          = 1'b0;
        case (r_estado)
            S_FETCH: begin
                LeMem         = 1'b1;
                EscreveIR     = 1'b1;
                EscrevePCBack = 1'b1;
                OrigAULA      = ULA_A_PC;
                OrigBULA      = ULA_B_4;
                EscrevePC     = 1'b1;
            end
            S_DECODE: begin
                OrigAULA = ULA_A_PCBACK;
                OrigBULA = ULA_B_IMM;
            end
            S_MEMADR: begin
                OrigAULA = ULA_A_REGA;
                OrigBULA = ULA_B_IMM;
            end
            S_MEMREAD: begin
                LeMem = 1'b1;
                IouD  = 1'b1;
            end
            S_MEMWB: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_MDR;
            end
            S_MEMWRITE: begin
                EscreveMem = 1'b1;
                IouD       = 1'b1;
            end
            S_EXEC_R: begin
                OrigAULA = ULA_A_REGA;
                OrigBULA = ULA_B_REGB;
                w_aluOp  = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                OrigAULA = ULA_A_REGA;
                OrigBULA = ULA_B_IMM;
                w_aluOp  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_ALUOUT;
            end
            S_BRANCH: begin
                OrigAULA      = ULA_A_REGA;
                OrigBULA      = ULA_B_REGB;
                w_aluOp       = ALUOP_SUB;
                EscrevePCCond = 1'b1;
                OrigPC        = PC_ALUOUT;
            end
            S_JAL: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_PC;
                EscrevePC  = 1'b1;
                OrigPC     = PC_ALUOUT;
            end
            S_JALR: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_PC;
                OrigAULA   = ULA_A_REGA;
                OrigBULA   = ULA_B_IMM;
                EscrevePC  = 1'b1;
                OrigPC     = PC_ALU_JALR;
            end
            S_LUI: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_IMM;
            end
            S_AUIPC: begin
                EscreveReg = 1'b1;
                Mem2Reg    = M2R_ALUOUT;
            end
            S_ERRO: begin
                Halt = 1'b1;
            end
            default: begin
                Halt = 1'b0;
            end
        endcase
    end

    assign ALUOp  = ALUOP_W'(w_aluOp);
    assign Estado = STATE_W'(r_estado);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: directed scenarios then random
// instruction streams, compared against per-instruction state lists.
module tb_controle_multiciclo;

    logic       clockCPU = 1'b0;
    logic       Reset    = 1'b0;
    logic       Passo    = 1'b0;
    logic [6:0] Opcode   = 7'd0;
    logic [3:0] Estado;
    logic       EscrevePC, EscrevePCCond, EscrevePCBack, IouD, LeMem;
    logic       EscreveMem, EscreveIR, EscreveReg, Halt;
    logic [1:0] Mem2Reg, OrigAULA, OrigBULA, ALUOp, OrigPC;

    int testsRun  = 0;
    int failCount = 0;

    typedef int intQ[$];

    controle_multiciclo dut (
        .clockCPU      (clockCPU),
        .Reset         (Reset),
`ifdef PASSO_A_PASSO_EN
        .Passo         (Passo),
`endif
        .Opcode        (Opcode),
        .Estado        (Estado),
        .EscrevePC     (EscrevePC),
        .EscrevePCCond (EscrevePCCond),
        .EscrevePCBack (EscrevePCBack),
        .IouD          (IouD),
        .LeMem         (LeMem),
        .EscreveMem    (EscreveMem),
        .EscreveIR     (EscreveIR),
        .EscreveReg    (EscreveReg),
        .Mem2Reg       (Mem2Reg),
        .OrigAULA      (OrigAULA),
        .OrigBULA      (OrigBULA),
        .ALUOp         (ALUOp),
        .OrigPC        (OrigPC),
        .Halt          (Halt)
    );

    always #5 clockCPU = ~clockCPU;

    wire [18:0] obsCtrl = {EscrevePC, EscrevePCCond, EscrevePCBack, IouD, LeMem,
                           EscreveMem, EscreveIR, EscreveReg, Mem2Reg, OrigAULA,
                           OrigBULA, ALUOp, OrigPC, Halt};

    // Control word required in each numbered state, read off the state table.
    function automatic logic [18:0] expCtrl(input int s);
        logic pc, pcc, pcb, iod, lm, em, ir, er, h;
        logic [1:0] m2r, a, b, op, opc;
        {pc, pcc, pcb, iod, lm, em, ir, er, h} = '0;
        {m2r, a, b, op, opc} = '0;
        case (s)
            0:  begin lm = 1; ir = 1; pcb = 1; a = 2'b10; b = 2'b01; pc = 1; end
            1:  begin a = 2'b00; b = 2'b10; end
            2:  begin a = 2'b01; b = 2'b10; end
            3:  begin lm = 1; iod = 1; end
            4:  begin er = 1; m2r = 2'b01; end
            5:  begin em = 1; iod = 1; end
            6:  begin a = 2'b01; b = 2'b00; op = 2'b10; end
            11: begin a = 2'b01; b = 2'b10; op = 2'b10; end
            7:  begin er = 1; end
            8:  begin a = 2'b01; op = 2'b01; pcc = 1; opc = 2'b01; end
            9:  begin er = 1; m2r = 2'b10; pc = 1; opc = 2'b01; end
            10: begin er = 1; m2r = 2'b10; a = 2'b01; b = 2'b10; pc = 1; opc = 2'b10; end
            12: begin er = 1; m2r = 2'b11; end
            13: begin er = 1; end
            15: begin h = 1; end
            default: ;
        endcase
        return {pc, pcc, pcb, iod, lm, em, ir, er, m2r, a, b, op, opc, h};
    endfunction

    // States visited after FETCH for one instruction of the given opcode.
    function automatic intQ buildSeq(input logic [6:0] op);
        intQ q;
        case (op)
            7'b0000011: q = '{1, 2, 3, 4};
            7'b0100011: q = '{1, 2, 5};
            7'b0110011: q = '{1, 6, 7};
            7'b0010011: q = '{1, 11, 7};
            7'b1100011: q = '{1, 8};
            7'b1101111: q = '{1, 9};
            7'b1100111: q = '{1, 10};
            7'b0110111: q = '{1, 12};
            7'b0010111: q = '{1, 13};
            default:    q = '{1, 15};
        endcase
        return q;
    endfunction

    task automatic tick();
        @(posedge clockCPU);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int expState);
        logic [3:0]  es;
        logic [18:0] ec;
        es = 4'(expState);
        ec = expCtrl(expState);
        testsRun++;
        assert (Estado === es) else begin
            failCount++;
            $error("[TB] FAIL %s: Estado observed %0d expected %0d", tag, Estado, es);
        end
        testsRun++;
        assert (obsCtrl === ec) else begin
            failCount++;
            $error("[TB] FAIL %s: controls observed %b expected %b (state %0d)", tag, obsCtrl, ec, expState);
        end
    endtask

    task automatic applyReset();
        Reset = 1'b0;
        #1;
        checkOutput("rstAsync", 0);
        tick();
        checkOutput("rstHeld", 0);
        Reset = 1'b1;
    endtask

    // Runs one instruction starting in FETCH; Opcode carries noise outside DECODE/MEMADR.
    task automatic applyStimulus(input logic [6:0] op, input int waitCycles);
        intQ seq;
        seq = buildSeq(op);
        checkOutput("fetch", 0);
        Opcode = 7'($urandom);
        tick();
        foreach (seq[i]) begin
            Opcode = (seq[i] == 1 || seq[i] == 2) ? op : 7'($urandom);
            checkOutput($sformatf("op%b_step%0d", op, i), seq[i]);
            tick();
        end
        if (seq[seq.size()-1] == 15) begin
            for (int k = 0; k < 19; k++) begin
                Opcode = 7'($urandom);
                checkOutput("erroHold", 15);
                tick();
            end
            applyReset();
        end else begin
`ifdef PASSO_A_PASSO_EN
            for (int k = 0; k < waitCycles; k++) begin
                checkOutput("espera", 14);
                tick();
            end
            Passo = 1'b1;
            checkOutput("esperaRise", 14);
            tick();
            checkOutput("esperaSync1", 14);
            tick();
            checkOutput("esperaSync2", 14);
            tick();
            Passo = 1'b0;
`endif
        end
    endtask

    localparam logic [6:0] LEGAL [9] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                         7'b0010011, 7'b1100011, 7'b1101111,
                                         7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        logic [6:0] op;
        #2;
        checkOutput("rstInit", 0);
        tick();
        checkOutput("rstInitHeld", 0);
        Reset = 1'b1;

        applyStimulus(7'b0000011, 2);
        applyStimulus(7'b0100011, 2);
        applyStimulus(7'b1100011, 2);
        applyStimulus(7'b1100111, 2);
        applyStimulus(7'b0110011, 10);
        applyStimulus(7'b0000000, 2);
        applyStimulus(7'b0110010, 2);

        // Abort a load in MEMREAD with an asynchronous reset.
        checkOutput("midFetch", 0);
        Opcode = 7'b0000011;
        tick();
        checkOutput("midDecode", 1);
        tick();
        checkOutput("midMemadr", 2);
        tick();
        checkOutput("midMemread", 3);
        applyReset();
        Opcode = 7'($urandom);
        tick();
        checkOutput("postRstDecode", 1);
        applyReset();

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) op = 7'($urandom);
            else                           op = LEGAL[$urandom_range(0, 8)];
            applyStimulus(op, $urandom_range(0, 6));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Main control FSM for the multicycle RV32I datapath. It sequences the shared memory, IR, register file, ALU and PC write-enables, one state per CPU clock. It runs on the divided CPU clock and exports the current state number for the board's 4-bit state display.

Parameters:
STATE_W, 4, width of the state register and of the Estado output
ALUOP_W, 2, width of the ALUOp field sent to the ALU control decoder

Ports:
clockCPU  input  1  CPU clock; all state updates on its rising edge
Reset  input  1  asynchronous, active-low reset
Opcode  input  7  IR[6:0]; valid from DECODE onward
Estado  output  STATE_W  current state number
EscrevePC  output  1  unconditional PC write
EscrevePCCond  output  1  PC write if ALU Zero (branch)
EscrevePCBack  output  1  latch PC into PCBack (address of current instruction)
IouD  output  1  memory address: 0 = PC, 1 = ALUOut
LeMem  output  1  memory read enable
EscreveMem  output  1  memory write enable
EscreveIR  output  1  IR load
EscreveReg  output  1  register-file write
Mem2Reg  output  2  write-back source: 00 ALUOut, 01 MDR, 10 PC (link), 11 Imm
OrigAULA  output  2  ALU A: 00 PCBack, 01 regA, 10 PC
OrigBULA  output  2  ALU B: 00 regB, 01 const 4, 10 Imm
ALUOp  output  ALUOP_W  00 add, 01 sub/compare (branch), 10 decode funct fields
OrigPC  output  2  PC source: 00 ALU result, 01 ALUOut, 10 ALU result with LSB cleared (jalr)
Halt  output  1  high while in ERRO

Behaviour:
- Moore FSM. Every control output is a pure decode of the state register. Outputs not listed for a state are 0.
- Reset low, asynchronously: state becomes FETCH (0) and stays there while Reset is low. Outputs take FETCH values immediately; Estado = 0.
- State numbering and actions:
  - 0 FETCH: LeMem, EscreveIR, EscrevePCBack, OrigAULA=10, OrigBULA=01, ALUOp=00, OrigPC=00, EscrevePC. Goes to DECODE.
  - 1 DECODE: OrigAULA=00, OrigBULA=10, ALUOp=00, so ALUOut = PCBack+imm. Dispatches on Opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> ERRO
  - 2 MEMADR: OrigAULA=01, OrigBULA=10, ALUOp=00. Goes to MEMREAD if Opcode=0000011, else MEMWRITE.
  - 3 MEMREAD: LeMem, IouD=1. Goes to MEMWB.
  - 4 MEMWB: EscreveReg, Mem2Reg=01. Goes to FETCH.
  - 5 MEMWRITE: EscreveMem, IouD=1. Goes to FETCH.
  - 6 EXEC_R: OrigAULA=01, OrigBULA=00, ALUOp=10. Goes to ALUWB.
  - 11 EXEC_I: OrigAULA=01, OrigBULA=10, ALUOp=10. Goes to ALUWB.
  - 7 ALUWB: EscreveReg, Mem2Reg=00. Goes to FETCH.
  - 8 BRANCH: OrigAULA=01, OrigBULA=00, ALUOp=01, EscrevePCCond, OrigPC=01. Goes to FETCH.
  - 9 JAL: EscreveReg, Mem2Reg=10, EscrevePC, OrigPC=01. Goes to FETCH.
  - 10 JALR: EscreveReg, Mem2Reg=10, OrigAULA=01, OrigBULA=10, ALUOp=00, EscrevePC, OrigPC=10. Goes to FETCH.
  - 12 LUI: EscreveReg, Mem2Reg=11. Goes to FETCH.
  - 13 AUIPC: EscreveReg, Mem2Reg=00 (ALUOut from DECODE). Goes to FETCH.
  - 15 ERRO: Halt=1, all write enables 0. Absorbing; only Reset exits.
  - 14 is unused; entering it forces ERRO on the next edge.
- Cycles per instruction, FETCH to FETCH: load 5; R/I/store 4; branch/jal/jalr/lui/auipc 3.
- Opcode is sampled only in DECODE and MEMADR. Its value in other states has no effect.
- Reset asserted mid-instruction aborts it. No partial write occurs after the asynchronous assertion, because outputs drop to FETCH values.
- Opcode bits [1:0] != 11 -> ERRO.

Optional Feature:
PASSO_A_PASSO_EN
- Defined: adds input Passo (1 bit, synchronised by two flops internally) and new state 14 ESPERA.
  - After any write-back/terminal state the FSM goes to ESPERA instead of FETCH.
  - ESPERA has all outputs 0.
  - It moves to FETCH on the cycle after a detected rising edge of synchronised Passo.
  - Reset still goes directly to FETCH.
- Undefined: no Passo port. State 14 is unused as described above.

Decomposition:
- Shared package controle_pkg holds:
  - state enum (4-bit, values above)
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_ITYPE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC)
  - Mem2Reg/OrigAULA/OrigBULA/ALUOp/OrigPC encodings
- One sub-module, decod_opcode: combinational Opcode -> dispatch state used by DECODE. Illegal opcodes map to ERRO.

Test Plan:
- Reset low mid-MEMREAD -> Estado=0 immediately, LeMem=1, EscreveIR=1, EscreveMem=0; release -> DECODE on next edge.
- Opcode=0000011 -> Estado sequence 0,1,2,3,4,0; IouD=1 in 3; EscreveReg=1 with Mem2Reg=01 only in 4.
- Opcode=0100011 -> 0,1,2,5,0; EscreveMem=1 only in 5; EscreveReg never 1.
- Opcode=1100011 -> 0,1,8,0; EscrevePCCond=1, ALUOp=01 in 8. Opcode=1100111 -> 0,1,10,0 with OrigPC=10, Mem2Reg=10.
- Opcode=0000000 -> 0,1,15,15,15; Halt=1, every enable 0 for 20 cycles; Reset low -> 0.
- With PASSO_A_PASSO_EN, Opcode=0110011 -> 0,1,6,7,14, holds 14 for 10 cycles. Passo pulse -> FETCH 3 cycles after the Passo rise.
